mlp_mac_sequencer: RTL and testbench
====================================

MLP_MAC_SEQUENCER -- requirements
Module: mlp_mac_sequencer

Interface
REQ-001 The module SHALL have parameter MAX_COLS_ROWS, default 4, giving the maximum matrix rows and cols.
REQ-002 The module SHALL have parameter MAX_WEIGHTS_SIZE, default 32, giving the weight memory depth.
REQ-003 The module SHALL have parameter DATA_SIZE, default 8, giving the operand and result width.
REQ-004 The module SHALL have parameter MAX_COL_ROW_BITS, default 4, giving the width of rows/cols.
REQ-005 Ports SHALL be exactly as follows; the design has one clock, and reset is asynchronous and active-low:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one matrix-vector product.
- rows  in  MAX_COL_ROW_BITS  output vector length; sampled with start.
- cols  in  MAX_COL_ROW_BITS  input vector length; sampled with start.
- layer_input  in  DATA_SIZE x MAX_COLS_ROWS  input vector; sampled with start.
- busy  out  1  high in any state other than IDLE.
- w_en  out  1  weight read strobe.
- w_addr  out  $clog2(MAX_WEIGHTS_SIZE)  weight address.
- w_data  in  DATA_SIZE  read data, valid the cycle after w_en.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- output_values  out  DATA_SIZE x MAX_COLS_ROWS  result vector.
- err  out  1  one-cycle pulse when start is rejected.

Function
REQ-006 The FSM SHALL have the states IDLE, REQ, ACC and HOLD.
REQ-007 In IDLE with start=1 and legal dimensions (rows<=MAX_COLS_ROWS, cols<=MAX_COLS_ROWS, both nonzero), the module SHALL latch rows, cols and layer_input, clear the accumulators, set i=j=0, and go to REQ.
REQ-008 In IDLE with start=1 and rows>MAX_COLS_ROWS or cols>MAX_COLS_ROWS, the module SHALL pulse err for 1 cycle and stay in IDLE.
REQ-009 In IDLE with start=1 and rows==0 or cols==0 (and neither over the limit), the module SHALL clear output_values and go directly to HOLD.
REQ-010 In REQ the module SHALL drive w_en=1 and w_addr=i*cols+j, then go to ACC.
REQ-011 In ACC the module SHALL compute p=w_data*x[j] at 2*DATA_SIZE width and update acc[i]; w_en SHALL be 0 in ACC.
REQ-012 Saturation rule: if p>2^DATA_SIZE-1, then acc[i]=all-ones; otherwise acc[i]=min(acc[i]+p, 2^DATA_SIZE-1), using a DATA_SIZE+1-bit sum.
REQ-013 Once acc[i] is all-ones it SHALL remain all-ones for the rest of the job.
REQ-014 After ACC, j SHALL increment. When j wraps at cols-1, j SHALL reset to 0 and i SHALL increment. After the final element (i=rows-1, j=cols-1) the FSM SHALL go to HOLD, otherwise back to REQ.
REQ-015 Latency SHALL be exactly 2*rows*cols cycles from the start-accept edge to out_valid=1.
REQ-016 In HOLD, out_valid SHALL be 1 and output_values SHALL be stable. Entries at index >= rows SHALL be 0.
REQ-017 In HOLD with out_ready=1, the FSM SHALL go to IDLE on that edge and out_valid SHALL drop on the next cycle.
REQ-018 start SHALL be ignored while busy=1; a start coincident with the HOLD-to-IDLE handshake SHALL also be ignored.
REQ-019 output_values SHALL keep its last result in IDLE until the next accepted start clears it.

Reset
REQ-020 On rst_n=0, asynchronously: FSM=IDLE; busy, w_en, out_valid and err = 0; w_addr=0; output_values all 0; i, j and latched dimensions = 0.
REQ-021 Reset mid-job SHALL abandon the job with no out_valid; the first start after reset SHALL behave exactly as after power-up.

Configuration
REQ-022 With MLP_SEQ_SAT_FLAG_EN defined, the module SHALL add output port sat_flags (MAX_COLS_ROWS bits). Bit i SHALL be set when row i saturated, be valid with out_valid, be cleared on accepted start, and be 0 on reset.
REQ-023 Without MLP_SEQ_SAT_FLAG_EN the sat_flags port SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Package mlp_pkg SHALL hold the FSM state enum mlp_seq_state_t and the saturation-max constant.
REQ-025 Sub-module sat_mac_unit SHALL implement REQ-012 combinationally (acc, w, x in; acc_next and sat out).

Verification
REQ-026 rows=2, cols=2, W={1,2,3,4}, x={5,6}: expect output_values={17,39,0,0], out_valid 8 cycles after accept, and w_addr sequence 0,1,2,3.
REQ-027 rows=1, cols=1, W=16, x=16 (p=256): expect output 255, and sat_flags[0]=1 when the macro is defined.
REQ-028 rows=1, cols=2, W={200,100}, x={1,1}: expect output 255; rows=1, cols=3, W={255,0,0}, x={1,5,5}: expect output stays 255.
REQ-029 start with rows=0, cols=3: expect HOLD next cycle, outputs all 0; start with rows=5: expect err pulse, busy stays 0.
REQ-030 Deassert rst_n during ACC of a 4x4 job: expect outputs 0 immediately; a subsequent 2x2 job must match REQ-026.
REQ-031 Hold out_ready=0 for 10 cycles in HOLD while pulsing start: expect results stable and start ignored; out_ready=1 returns the FSM to IDLE.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared FSM state type and saturation constant for the MLP MAC sequencer.
package mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } mlp_seq_state_t;

    localparam int unsigned              MLP_DATA_SIZE = 8;
    localparam logic [MLP_DATA_SIZE-1:0] MLP_SAT_MAX   = '1;

endpackage

// File: rtl/sat_mac_unit.sv
// Combinational saturating multiply-accumulate step: acc_next = sat(acc + w*x).
module sat_mac_unit
    import mlp_pkg::*;
#(
    parameter int unsigned          DATA_SIZE = MLP_DATA_SIZE,
    parameter logic [DATA_SIZE-1:0] SAT_MAX   = MLP_SAT_MAX
) (
    input  logic [DATA_SIZE-1:0] acc,
    input  logic [DATA_SIZE-1:0] w,
    input  logic [DATA_SIZE-1:0] x,
    output logic [DATA_SIZE-1:0] acc_next,
    output logic                 sat
);

    localparam int unsigned PROD_W = 2 * DATA_SIZE;

    logic [PROD_W-1:0]  w_prod;
    logic [DATA_SIZE:0] w_sum;
    logic               w_prod_over;
    logic               w_sum_over;

    assign w_prod      = PROD_W'(w) * PROD_W'(x);
    assign w_prod_over = w_prod > PROD_W'(SAT_MAX);
    // The low product bits only matter when the product itself fits in DATA_SIZE.
    assign w_sum       = {1'b0, acc} + {1'b0, w_prod[DATA_SIZE-1:0]};
    assign w_sum_over  = w_sum > {1'b0, SAT_MAX};

    assign sat      = w_prod_over | w_sum_over;
    assign acc_next = sat ? SAT_MAX : w_sum[DATA_SIZE-1:0];

endmodule

// File: rtl/mlp_mac_sequencer.sv
// Sequences one saturating matrix-vector product through an external weight memory.
// Optional build macro MLP_SEQ_SAT_FLAG_EN adds the per-row sat_flags output.
module mlp_mac_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned MAX_COLS_ROWS    = 4,
    parameter int unsigned MAX_WEIGHTS_SIZE = 32,
    parameter int unsigned DATA_SIZE        = MLP_DATA_SIZE,
    parameter int unsigned MAX_COL_ROW_BITS = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [MAX_COL_ROW_BITS-1:0]         rows,
    input  logic [MAX_COL_ROW_BITS-1:0]         cols,
    input  logic [DATA_SIZE*MAX_COLS_ROWS-1:0]  layer_input,
    output logic                                busy,
    output logic                                w_en,
    output logic [$clog2(MAX_WEIGHTS_SIZE)-1:0] w_addr,
    input  logic [DATA_SIZE-1:0]                w_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_SIZE*MAX_COLS_ROWS-1:0]  output_values,
    output logic                                err
`ifdef MLP_SEQ_SAT_FLAG_EN
    ,
    output logic [MAX_COLS_ROWS-1:0]            sat_flags
`endif
);

    localparam int unsigned ADDR_W = $clog2(MAX_WEIGHTS_SIZE);
    localparam int unsigned IDX_W  = (MAX_COLS_ROWS > 1) ? $clog2(MAX_COLS_ROWS) : 1;
    localparam int unsigned DIM_W  = MAX_COL_ROW_BITS;

    localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(MAX_COLS_ROWS);
    localparam logic [DIM_W-1:0] ONE_DIM = DIM_W'(1);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    mlp_seq_state_t r_state;
    mlp_seq_state_t w_next_state;

    logic [DIM_W-1:0]     r_rows;
    logic [DIM_W-1:0]     r_cols;
    logic [IDX_W-1:0]     r_i;
    logic [IDX_W-1:0]     r_j;
    logic [DATA_SIZE-1:0] r_x   [MAX_COLS_ROWS];
    logic [DATA_SIZE-1:0] r_acc [MAX_COLS_ROWS];
    logic                 r_err;

    logic                 w_idle_start;
    logic                 w_dims_over;
    logic                 w_dims_zero;
    logic                 w_accept;
    logic                 w_accept_zero;
    logic                 w_last_i;
    logic                 w_last_j;
    logic [ADDR_W-1:0]    w_addr_calc;
    logic [DATA_SIZE-1:0] w_acc_next;
    logic                 w_sat;

    assign w_idle_start  = (r_state == IDLE) && start;
    assign w_dims_over   = (rows > MAX_DIM) || (cols > MAX_DIM);
    assign w_dims_zero   = (rows == '0) || (cols == '0);
    assign w_accept      = w_idle_start && !w_dims_over && !w_dims_zero;
    assign w_accept_zero = w_idle_start && !w_dims_over && w_dims_zero;

    assign w_last_i    = (DIM_W'(r_i) + ONE_DIM) == r_rows;
    assign w_last_j    = (DIM_W'(r_j) + ONE_DIM) == r_cols;
    assign w_addr_calc = ADDR_W'(r_i) * ADDR_W'(r_cols) + ADDR_W'(r_j);

    sat_mac_unit #(
        .DATA_SIZE (DATA_SIZE),
        .SAT_MAX   ({DATA_SIZE{1'b1}})
    ) u_sat_mac (
        .acc      (r_acc[r_i]),
        .w        (w_data),
        .x        (r_x[r_j]),
        .acc_next (w_acc_next),
        .sat      (w_sat)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != IDLE);
        w_en         = 1'b0;
        w_addr       = '0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = REQ;
                end else if (w_accept_zero) begin
                    w_next_state = HOLD;
                end
            end
            REQ: begin
                w_en         = 1'b1;
                w_addr       = w_addr_calc;
                w_next_state = ACC;
            end
            ACC: begin
                w_next_state = (w_last_i && w_last_j) ? HOLD : REQ;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: the accumulator array is tiny and must read 0 out of reset, so it is reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows <= '0;
            r_cols <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_err  <= 1'b0;
            for (int k = 0; k < MAX_COLS_ROWS; k++) begin
                r_x[k]   <= '0;
                r_acc[k] <= '0;
            end
        end else begin
            r_err <= w_idle_start && w_dims_over;
            if (w_accept || w_accept_zero) begin
                r_rows <= rows;
                r_cols <= cols;
                r_i    <= '0;
                r_j    <= '0;
                for (int k = 0; k < MAX_COLS_ROWS; k++) begin
                    r_x[k]   <= layer_input[k*DATA_SIZE +: DATA_SIZE];
                    r_acc[k] <= '0;
                end
            end else if (r_state == ACC) begin
                r_acc[r_i] <= w_acc_next;
                if (w_last_j) begin
                    r_j <= '0;
                    if (!w_last_i) begin
                        r_i <= r_i + ONE_IDX;
                    end
                end else begin
                    r_j <= r_j + ONE_IDX;
                end
            end
        end
    end

    assign err = r_err;

    for (genvar g = 0; g < MAX_COLS_ROWS; g++) begin : g_out
        assign output_values[g*DATA_SIZE +: DATA_SIZE] = r_acc[g];
    end

`ifdef MLP_SEQ_SAT_FLAG_EN
    logic [MAX_COLS_ROWS-1:0] r_sat_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flags <= '0;
        end else if (w_accept || w_accept_zero) begin
            r_sat_flags <= '0;
        end else if ((r_state == ACC) && w_sat) begin
            r_sat_flags[r_i] <= 1'b1;
        end
    end

    assign sat_flags = r_sat_flags;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat;
`endif

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Directed self-checking bench for mlp_mac_sequencer with a weight-memory model and scoreboard.
module tb_mlp_mac_sequencer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CB = 4;

    typedef struct packed {
        logic [DW*N-1:0] vals;
        logic [N-1:0]    sat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CB-1:0] rows;
    logic [CB-1:0] cols;
    logic [DW*N-1:0] layer_input;
    logic          busy;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW*N-1:0] output_values;
    logic          err;
`ifdef MLP_SEQ_SAT_FLAG_EN
    logic [N-1:0]  sat_flags;
`endif

    logic [DW-1:0] w_mem [32];
    logic [AW-1:0] addr_log [$];
    exp_t          sb_q [$];

    int checks = 0;
    int errors = 0;

    mlp_mac_sequencer #(
        .MAX_COLS_ROWS    (N),
        .MAX_WEIGHTS_SIZE (32),
        .DATA_SIZE        (DW),
        .MAX_COL_ROW_BITS (CB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rows          (rows),
        .cols          (cols),
        .layer_input   (layer_input),
        .busy          (busy),
        .w_en          (w_en),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .output_values (output_values),
        .err           (err)
`ifdef MLP_SEQ_SAT_FLAG_EN
        ,
        .sat_flags     (sat_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: one-cycle read latency, every requested address logged.
    always @(posedge clk) begin
        if (w_en) begin
            w_data <= w_mem[w_addr];
            addr_log.push_back(w_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int nr, input int nc, input logic [DW*N-1:0] xv);
        exp_t e;
        e.vals = '0;
        e.sat  = '0;
        for (int i = 0; i < nr; i++) begin
            int acc;
            acc = 0;
            for (int j = 0; j < nc; j++) begin
                int p;
                p = int'(w_mem[i*nc+j]) * int'(xv[j*DW +: DW]);
                if (p > 255 || acc + p > 255) begin
                    acc      = 255;
                    e.sat[i] = 1'b1;
                end else begin
                    acc = acc + p;
                end
            end
            e.vals[i*DW +: DW] = 8'(acc);
        end
        return e;
    endfunction

    task automatic run_job(input string tag, input int nr, input int nc,
                           input logic [DW*N-1:0] xv, output exp_t e);
        int k;
        @(negedge clk);
        addr_log.delete();
        rows        = CB'(nr);
        cols        = CB'(nc);
        layer_input = xv;
        start       = 1'b1;
        sb_q.push_back(model(nr, nc, xv));
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(2*nr*nc));
        check({tag, " addr count"}, 64'(addr_log.size()), 64'(nr*nc));
        for (int a = 0; a < addr_log.size() && a < nr*nc; a++) begin
            check({tag, " addr"}, 64'(addr_log[a]), 64'(a));
        end
        e = sb_q.pop_front();
        check({tag, " values"}, 64'(output_values), 64'(e.vals));
        check({tag, " busy in hold"}, 64'(busy), 64'(1));
`ifdef MLP_SEQ_SAT_FLAG_EN
        check({tag, " sat_flags"}, 64'(sat_flags), 64'(e.sat));
`endif
    endtask

    task automatic finish_job(input string tag, input exp_t e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid drop"}, 64'(out_valid), 64'(0));
        check({tag, " idle"}, 64'(busy), 64'(0));
        check({tag, " retained"}, 64'(output_values), 64'(e.vals));
    endtask

    initial begin
        exp_t e;
        int   k;
        logic seen_valid;

        rst_n       = 1'b0;
        start       = 1'b0;
        rows        = '0;
        cols        = '0;
        layer_input = '0;
        out_ready   = 1'b0;
        for (int a = 0; a < 32; a++) w_mem[a] = '0;

        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset w_en", 64'(w_en), 64'(0));
        check("reset w_addr", 64'(w_addr), 64'(0));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset err", 64'(err), 64'(0));
        check("reset values", 64'(output_values), 64'(0));
`ifdef MLP_SEQ_SAT_FLAG_EN
        check("reset sat_flags", 64'(sat_flags), 64'(0));
`endif
        rst_n = 1'b1;

        // 2x2 reference product.
        w_mem[0] = 8'd1; w_mem[1] = 8'd2; w_mem[2] = 8'd3; w_mem[3] = 8'd4;
        run_job("2x2", 2, 2, 32'h0000_0605, e);
        check("2x2 literal", 64'(output_values), 64'h0000_2711);
        finish_job("2x2", e);

        // Product overflow on a single element.
        w_mem[0] = 8'd16;
        run_job("1x1 sat", 1, 1, 32'h0000_0010, e);
        check("1x1 literal", 64'(output_values), 64'h0000_00ff);
`ifdef MLP_SEQ_SAT_FLAG_EN
        check("1x1 sat bit", 64'(sat_flags[0]), 64'(1));
`endif
        finish_job("1x1 sat", e);

        // Sum overflow, then sticky all-ones.
        w_mem[0] = 8'd200; w_mem[1] = 8'd100;
        run_job("1x2 sum", 1, 2, 32'h0000_0101, e);
        check("1x2 literal", 64'(output_values), 64'h0000_00ff);
        finish_job("1x2 sum", e);

        w_mem[0] = 8'd255; w_mem[1] = 8'd0; w_mem[2] = 8'd0;
        run_job("1x3 stick", 1, 3, 32'h0005_0501, e);
        check("1x3 literal", 64'(output_values), 64'h0000_00ff);
        finish_job("1x3 stick", e);

        // Full-size job with mixed saturation.
        for (int a = 0; a < 16; a++) w_mem[a] = 8'((a*7 + 3) % 23);
        run_job("4x4", 4, 4, 32'h0209_0403, e);
        finish_job("4x4", e);

        // Zero dimension goes straight to HOLD with cleared outputs.
        run_job("zero rows", 0, 3, 32'h0101_0101, e);
        check("zero w_en", 64'(w_en), 64'(0));
        finish_job("zero rows", e);

        // Over-limit dimensions are rejected with a one-cycle err pulse.
        @(negedge clk);
        rows = 4'd5; cols = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rows5 err", 64'(err), 64'(1));
        check("rows5 busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("rows5 err drop", 64'(err), 64'(0));
        check("rows5 still idle", 64'(busy), 64'(0));
        rows = 4'd0; cols = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cols9 err", 64'(err), 64'(1));
        check("cols9 busy", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a 4x4 job.
        @(negedge clk);
        rows = 4'd4; cols = 4'd4; layer_input = 32'h0209_0403; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("acc w_en", 64'(w_en), 64'(0));
        check("acc busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midreset values", 64'(output_values), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset out_valid", 64'(out_valid), 64'(0));
        check("midreset w_en", 64'(w_en), 64'(0));
        check("midreset w_addr", 64'(w_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("no valid after reset", 64'(seen_valid), 64'(0));

        w_mem[0] = 8'd1; w_mem[1] = 8'd2; w_mem[2] = 8'd3; w_mem[3] = 8'd4;
        run_job("2x2 post reset", 2, 2, 32'h0000_0605, e);
        check("2x2 post reset literal", 64'(output_values), 64'h0000_2711);
        finish_job("2x2 post reset", e);

        // Back-pressure in HOLD with start pulses that must be ignored.
        for (int a = 0; a < 6; a++) w_mem[a] = 8'((a + 1) * 10);
        run_job("3x2 hold", 3, 2, 32'h0000_0302, e);
        check("3x2 literal", 64'(output_values), 64'h00ff_b450);
        for (int c = 0; c < 10; c++) begin
            start       = (c % 2 == 0);
            rows        = 4'd2;
            cols        = 4'd2;
            layer_input = 32'h0101_0101;
            @(negedge clk);
            check("hold stable", 64'(output_values), 64'(e.vals));
            check("hold valid", 64'(out_valid), 64'(1));
            check("hold no fetch", 64'(w_en), 64'(0));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("handshake valid drop", 64'(out_valid), 64'(0));
        check("handshake start ignored", 64'(busy), 64'(0));
        check("handshake retained", 64'(output_values), 64'(e.vals));
        @(negedge clk);
        check("still idle", 64'(busy), 64'(0));
        check("no stray fetch", 64'(w_en), 64'(0));

        k = sb_q.size();
        check("scoreboard drained", 64'(k), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
